// File: rtl/lfsr_seq_checker.sv
// Sequence checker for the 8-bit PRNG stage. It seeds from the incoming words,
// locks after a run of correct predictions, then flywheels and counts mismatches.
module lfsr_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_seen
);

  localparam int MR_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_CNT + 1);
  localparam logic [MR_W-1:0] LOCK_LAST = MR_W'(LOCK_CNT - 1);
  localparam logic [MS_W-1:0] LOSS_LAST = MS_W'(LOSS_CNT - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  function automatic logic [7:0] nxt(input logic [7:0] w);
    return {w[6:0], w[7] ^ w[3] ^ w[2] ^ w[1]};
  endfunction

  state_t           state_q, state_d;
  logic             have_seed_q, have_seed_d;
  logic [7:0]       pred_q, pred_d;
  logic [MR_W-1:0]  match_run_q, match_run_d;
  logic [MS_W-1:0]  miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             zero_seen_q, zero_seen_d;
  logic             hit;

  always_comb begin
    state_d     = state_q;
    have_seed_d = have_seed_q;
    pred_d      = pred_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    zero_seen_d = zero_seen_q;
    hit         = (in_data == pred_q);

    if (in_valid) begin
      if (in_data == 8'h00) begin
        zero_seen_d = 1'b1;
      end

      if (state_q == HUNT) begin
        // A zero word can never be part of the sequence, so it drops the seed.
        if (in_data == 8'h00) begin
          have_seed_d = 1'b0;
          match_run_d = '0;
        end else if (!have_seed_q) begin
          pred_d      = nxt(in_data);
          have_seed_d = 1'b1;
          match_run_d = '0;
        end else if (hit) begin
          pred_d      = nxt(in_data);
          match_run_d = match_run_q + MR_W'(1);
          if (match_run_q == LOCK_LAST) begin
            state_d    = LOCKED;
            locked_d   = 1'b1;
            miss_run_d = '0;
          end
        end else begin
          pred_d      = nxt(in_data);
          match_run_d = '0;
        end
      end else begin
        // Flywheel: prediction advances from itself so bit errors do not reseed.
        pred_d = nxt(pred_q);
        if (hit) begin
          miss_run_d = '0;
        end else begin
          err_pulse_d = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          miss_run_d = miss_run_q + MS_W'(1);
          if (miss_run_q == LOSS_LAST) begin
            state_d     = HUNT;
            locked_d    = 1'b0;
            have_seed_d = 1'b0;
            match_run_d = '0;
            miss_run_d  = '0;
          end
        end
      end
    end

    if (clr_err) begin
      err_cnt_d   = '0;
      zero_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      have_seed_q <= 1'b0;
      pred_q      <= '0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_seed_q <= have_seed_d;
      pred_q      <= pred_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: a default instance and an ERR_W=2
// instance share the stimulus; a behavioural model queues expected outputs.
module tb_lfsr_seq_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr_err = 1'b0;
  logic        locked, err_pulse, zero_seen;
  logic [15:0] err_cnt;
  logic        s_locked, s_err_pulse, s_zero_seen;
  logic [1:0]  s_err_cnt;

  always #5 clk = ~clk;

  lfsr_seq_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .zero_seen(zero_seen)
  );

  lfsr_seq_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_cnt(s_err_cnt), .zero_seen(s_zero_seen)
  );

  typedef struct packed {
    logic        lk;
    logic        pulse;
    logic [15:0] err;
    logic [1:0]  errs;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  // Behavioural reference state
  bit   m_locked, m_seed, m_zero, m_pulse;
  int   m_pred, m_mrun, m_mis, m_err, m_errs;
  logic [7:0] gen;

  function automatic logic [7:0] lfsr_next(input logic [7:0] w);
    return (w << 1) | {7'd0, ^(w & 8'h8E)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_seed = 0; m_zero = 0; m_pulse = 0;
    m_pred = 0; m_mrun = 0; m_mis = 0; m_err = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit c);
    bit match;
    m_pulse = 0;
    if (v) begin
      if (d == 8'h00) m_zero = 1;
      if (!m_locked) begin
        if (d == 8'h00) begin
          m_seed = 0; m_mrun = 0;
        end else if (!m_seed) begin
          m_pred = int'(lfsr_next(d)); m_seed = 1; m_mrun = 0;
        end else if (int'(d) == m_pred) begin
          m_pred = int'(lfsr_next(d));
          m_mrun = m_mrun + 1;
          if (m_mrun == LOCK_N) begin m_locked = 1; m_mis = 0; end
        end else begin
          m_pred = int'(lfsr_next(d)); m_mrun = 0;
        end
      end else begin
        match  = (int'(d) == m_pred);
        m_pred = int'(lfsr_next(8'(m_pred)));
        if (match) m_mis = 0;
        else begin
          m_pulse = 1;
          if (m_err < 65535) m_err = m_err + 1;
          if (m_errs < 3) m_errs = m_errs + 1;
          m_mis = m_mis + 1;
          if (m_mis == LOSS_N) begin m_locked = 0; m_seed = 0; m_mrun = 0; end
        end
      end
    end
    if (c) begin m_err = 0; m_errs = 0; m_zero = 0; end
  endtask

  // One transaction: drive at negedge, queue expectation, compare after the edge.
  task automatic drive(input bit v, input logic [7:0] d, input bit c);
    exp_t e, got;
    @(negedge clk);
    in_valid = v; in_data = d; clr_err = c;
    model_step(v, d, c);
    e.lk = m_locked; e.pulse = m_pulse; e.err = 16'(m_err); e.errs = 2'(m_errs); e.zero = m_zero;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_txn++;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("locked", 32'(locked), 32'(got.lk));
      chk("err_pulse", 32'(err_pulse), 32'(got.pulse));
      chk("err_cnt", 32'(err_cnt), 32'(got.err));
      chk("zero_seen", 32'(zero_seen), 32'(got.zero));
      chk("sat_err_cnt", 32'(s_err_cnt), 32'(got.errs));
      chk("sat_locked", 32'(s_locked), 32'(got.lk));
    end
    $display("txn %0d v=%0b d=%02h clr=%0b -> locked=%0b pulse=%0b err=%0d sat=%0d zero=%0b",
             n_txn, v, d, c, locked, err_pulse, err_cnt, s_err_cnt, zero_seen);
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic send_true();
    drive(1'b1, gen, 1'b0);
    gen = lfsr_next(gen);
  endtask

  task automatic send_bad(input logic [7:0] mask);
    drive(1'b1, gen ^ mask, 1'b0);
    gen = lfsr_next(gen);
  endtask

  task automatic send_zero(input bit c);
    drive(1'b1, 8'h00, c);
    gen = lfsr_next(gen);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_pulse"}, 32'(err_pulse), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_zero"}, 32'(zero_seen), 32'd0);
    chk({tag, "_sat_err"}, 32'(s_err_cnt), 32'd0);
    chk({tag, "_sat_zero"}, 32'(s_zero_seen), 32'd0);
  endtask

  task automatic run_t1();
    logic [7:0] t1_seq [6];
    t1_seq = '{8'h80, 8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, t1_seq[i], 1'b0);
      if (i == 3) chk("t1_not_yet_locked", 32'(locked), 32'd0);
      if (i == 4) chk("t1_locked_after_0B", 32'(locked), 32'd1);
    end
    gen = lfsr_next(8'h16);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // T1: lock onto the reference sequence
    run_t1();
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // T2: single corrupted word
    send_bad(8'h10);
    for (int i = 0; i < 4; i++) send_true();
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_locked", 32'(locked), 32'd1);

    // T3: three consecutive errors drop lock, five good words relock
    for (int i = 0; i < 3; i++) send_bad(8'h10);
    chk("t3_unlocked", 32'(locked), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd4);
    for (int i = 0; i < 5; i++) send_true();
    chk("t3_relocked", 32'(locked), 32'd1);

    // T4: random idle gaps between true words
    for (int i = 0; i < 10; i++) begin
      int gap_n;
      gap_n = int'($urandom_range(1, 7));
      for (int g = 0; g < gap_n; g++) drive(1'b0, 8'($urandom), 1'b0);
      send_true();
    end
    chk("t4_err_cnt", 32'(err_cnt), 32'd4);

    // Saturation of the 2-bit counter with isolated errors
    for (int i = 0; i < 5; i++) begin
      send_bad(8'h41);
      for (int k = 0; k < 3; k++) send_true();
    end
    chk("sat_cnt_max", 32'(s_err_cnt), 32'd3);
    chk("sat_main_cnt", 32'(err_cnt), 32'd9);

    // T5: zero word with simultaneous clear, then a zero word alone
    send_zero(1'b1);
    chk("t5_clr_pulse", 32'(err_pulse), 32'd1);
    chk("t5_clr_err", 32'(err_cnt), 32'd0);
    chk("t5_clr_zero", 32'(zero_seen), 32'd0);
    send_zero(1'b0);
    chk("t5_err_one", 32'(err_cnt), 32'd1);
    chk("t5_zero_set", 32'(zero_seen), 32'd1);
    chk("t5_still_locked", 32'(locked), 32'd1);
    send_true();
    send_bad(8'h10);
    send_true();
    chk("t6_pre_err", 32'(err_cnt), 32'd2);

    // T6: asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Zero word while hunting sets zero_seen only; a bare clear removes it
    drive(1'b1, 8'h00, 1'b0);
    chk("hunt_zero_seen", 32'(zero_seen), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    chk("hunt_zero_clr", 32'(zero_seen), 32'd0);
    run_t1();
    send_true();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
